// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: ping-pong sequencer for an external up/down loadable
// counter. Loads lo, counts up to hi, back down to lo, and repeats for the
// requested number of passes. Host side is start/abort with busy/done/err.
//
// Optional build macro COUNTER_SEQ_DWELL_EN adds a DWELL state that holds the
// counter at hi for DW tick cycles before the down sweep. DW must be >= 1
// when the macro is defined. In the default build DW has no effect.
module counter_seq_ctrl #(
  parameter int M  = 4,
  parameter int R  = 4,
  parameter int DW = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         abort,
  input  logic         tick,
  input  logic [M-1:0] lo,
  input  logic [M-1:0] hi,
  input  logic [R-1:0] reps,
  input  logic [M-1:0] cnt_q,
  output logic         cnt_ce,
  output logic         cnt_up,
  output logic         cnt_l,
  output logic [M-1:0] cnt_di,
  output logic         cnt_clr,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [R-1:0] rep_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
`ifdef COUNTER_SEQ_DWELL_EN
    S_DONE,
    S_DWELL
`else
    S_DONE
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [R-1:0] rep_left_q, rep_left_d;
  logic [R-1:0] rep_done_q, rep_done_d;
  logic         err_q;
  logic         accept, reject;

  // Bounds are captured once per accepted start; they are data, not control.
  logic [M-1:0] lo_q, hi_q;

`ifdef COUNTER_SEQ_DWELL_EN
  localparam int DWW = (DW < 2) ? 1 : $clog2(DW + 1);
  localparam logic [DWW-1:0] DW_LAST = DWW'(DW - 1);
  logic [DWW-1:0] dwell_q, dwell_d;
`endif

  // Next-state and counter-control decode; abort overrides any transition.
  always_comb begin
    state_d    = state_q;
    rep_left_d = rep_left_q;
    rep_done_d = rep_done_q;
    accept     = 1'b0;
    reject     = 1'b0;
    cnt_ce     = 1'b0;
    cnt_up     = 1'b1;
    cnt_l      = 1'b0;
`ifdef COUNTER_SEQ_DWELL_EN
    dwell_d    = dwell_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            accept     = 1'b1;
            rep_left_d = (reps == '0) ? R'(1) : reps;
            rep_done_d = '0;
            state_d    = S_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cnt_l   = 1'b1;
        state_d = S_UP;
      end
      S_UP: begin
        // Never step at the terminal value, so the counter cannot wrap.
        cnt_ce = tick & (cnt_q != hi_q);
        if (cnt_q == hi_q) begin
`ifdef COUNTER_SEQ_DWELL_EN
          dwell_d = '0;
          state_d = S_DWELL;
`else
          state_d = S_DOWN;
`endif
        end
      end
`ifdef COUNTER_SEQ_DWELL_EN
      S_DWELL: begin
        if (tick) begin
          if (dwell_q == DW_LAST) begin
            state_d = S_DOWN;
          end else begin
            dwell_d = dwell_q + DWW'(1);
          end
        end
      end
`endif
      S_DOWN: begin
        cnt_up = 1'b0;
        cnt_ce = tick & (cnt_q != lo_q);
        if (cnt_q == lo_q) begin
          rep_done_d = rep_done_q + R'(1);
          if (rep_left_q == R'(1)) begin
            state_d = S_DONE;
          end else begin
            rep_left_d = rep_left_q - R'(1);
            state_d    = S_UP;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      rep_left_d = rep_left_q;
      rep_done_d = rep_done_q;
      accept     = 1'b0;
      reject     = 1'b0;
    end
  end

  // Control state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      rep_left_q <= '0;
      rep_done_q <= '0;
      err_q      <= 1'b0;
`ifdef COUNTER_SEQ_DWELL_EN
      dwell_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rep_left_q <= rep_left_d;
      rep_done_q <= rep_done_d;
      err_q      <= reject;
`ifdef COUNTER_SEQ_DWELL_EN
      dwell_q    <= dwell_d;
`endif
    end
  end

  // Capture the bounds when a start is accepted; held until the next one.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_q <= lo;
      hi_q <= hi;
    end
  end

  assign cnt_di   = lo_q;
  assign cnt_clr  = clr | abort;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign rep_done = rep_done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;
  localparam int M  = 4;
  localparam int R  = 4;
  localparam int DW = 3;

  logic         clk = 1'b0;
  logic         clr, start, abort, tick;
  logic [M-1:0] lo, hi;
  logic [R-1:0] reps;
  logic [M-1:0] cnt_q;
  logic         cnt_ce, cnt_up, cnt_l, cnt_clr, busy, done, err;
  logic [M-1:0] cnt_di;
  logic [R-1:0] rep_done;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.M(M), .R(R), .DW(DW)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .tick(tick),
    .lo(lo), .hi(hi), .reps(reps), .cnt_q(cnt_q),
    .cnt_ce(cnt_ce), .cnt_up(cnt_up), .cnt_l(cnt_l), .cnt_di(cnt_di),
    .cnt_clr(cnt_clr), .busy(busy), .done(done), .err(err),
    .rep_done(rep_done)
  );

  // Model of the attached up/down loadable counter: clr > load > ce.
  always_ff @(posedge clk) begin
    if (cnt_clr)     cnt_q <= '0;
    else if (cnt_l)  cnt_q <= cnt_di;
    else if (cnt_ce) cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0;
    lo = '0; hi = '0; reps = '0;
    repeat (2) cyc();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0d exp 0", err); end
    checks++; if (rep_done !== 4'd0) begin errors++; $display("FAIL reset_rep_done got %0d exp 0", rep_done); end
    checks++; if (cnt_ce !== 1'b0 || cnt_l !== 1'b0 || cnt_up !== 1'b1) begin
      errors++; $display("FAIL reset_cnt_ctrl got ce=%0d l=%0d up=%0d exp ce=0 l=0 up=1", cnt_ce, cnt_l, cnt_up);
    end
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL reset_cnt_clr got %0d exp 1", cnt_clr); end
    cyc();
    clr = 1'b0;
    #1;
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL release_cnt_clr got %0d exp 0", cnt_clr); end
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt_q got %0d exp 0", cnt_q); end
  endtask

  task automatic test_basic();
    logic [M-1:0] exp_q [0:7];
    exp_q = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2};
    lo = 4'd2; hi = 4'd5; reps = 4'd1; tick = 1'b1; start = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c0 got %0d exp 0", busy); end
    for (int c = 1; c <= 12; c++) begin
      cyc();
      start = 1'b0;
      #1;
      checks++; if (busy !== (c <= 10)) begin errors++; $display("FAIL basic_busy_c%0d got %0d exp %0d", c, busy, (c <= 10)); end
      checks++; if (done !== (c == 10)) begin errors++; $display("FAIL basic_done_c%0d got %0d exp %0d", c, done, (c == 10)); end
      if (c == 1) begin
        checks++; if (cnt_l !== 1'b1 || cnt_ce !== 1'b0) begin errors++; $display("FAIL basic_load got l=%0d ce=%0d exp l=1 ce=0", cnt_l, cnt_ce); end
      end
      if (c >= 2 && c <= 9) begin
        checks++; if (cnt_q !== exp_q[c-2]) begin errors++; $display("FAIL basic_q_c%0d got %0d exp %0d", c, cnt_q, exp_q[c-2]); end
      end
    end
    checks++; if (rep_done !== 4'd1) begin errors++; $display("FAIL basic_rep_done got %0d exp 1", rep_done); end
  endtask

  task automatic test_reps();
    int ndone = 0;
    int done_at = -1;
    bit wrap = 1'b0;
    bit bad_ce = 1'b0;
    logic [M-1:0] prev;
    lo = 4'd0; hi = 4'd15; reps = 4'd3; tick = 1'b1; start = 1'b1;
    #1;
    prev = cnt_q;
    for (int c = 1; c <= 110; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (done) begin ndone++; done_at = c; end
      if (c >= 3 && prev == 4'd15 && cnt_q == 4'd0) wrap = 1'b1;
      if (cnt_ce && ((cnt_up && cnt_q == 4'd15) || (!cnt_up && cnt_q == 4'd0))) bad_ce = 1'b1;
      prev = cnt_q;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL reps3_done_count got %0d exp 1", ndone); end
    checks++; if (done_at != 98) begin errors++; $display("FAIL reps3_done_cycle got %0d exp 98", done_at); end
    checks++; if (rep_done !== 4'd3) begin errors++; $display("FAIL reps3_rep_done got %0d exp 3", rep_done); end
    checks++; if (wrap) begin errors++; $display("FAIL reps3_wrap got 1 exp 0"); end
    checks++; if (bad_ce) begin errors++; $display("FAIL reps3_ce_at_terminal got 1 exp 0"); end
  endtask

  task automatic test_reps_zero();
    int done_at = -1;
    lo = 4'd2; hi = 4'd5; reps = 4'd0; tick = 1'b1; start = 1'b1;
    #1;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (done) done_at = c;
    end
    checks++; if (done_at != 10) begin errors++; $display("FAIL reps0_done_cycle got %0d exp 10", done_at); end
    checks++; if (rep_done !== 4'd1) begin errors++; $display("FAIL reps0_rep_done got %0d exp 1", rep_done); end
  endtask

  task automatic test_tick_gating();
    int done_at = -1;
    bit bad_ce = 1'b0;
    bit bad_step = 1'b0;
    logic [M-1:0] prev, q7, q13;
    logic prev_tick;
    q7 = '0; q13 = '0;
    lo = 4'd1; hi = 4'd3; reps = 4'd1; tick = 1'b1; start = 1'b1;
    #1;
    prev = cnt_q; prev_tick = tick;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      start = 1'b0;
      tick = ((c % 3) == 0);
      #1;
      if (cnt_ce && !tick) bad_ce = 1'b1;
      if (c >= 3 && cnt_q !== prev && !prev_tick) bad_step = 1'b1;
      if (done) done_at = c;
      if (c == 7) q7 = cnt_q;
      if (c == 13) q13 = cnt_q;
      prev = cnt_q; prev_tick = tick;
    end
    checks++; if (bad_ce) begin errors++; $display("FAIL tick_ce_without_tick got 1 exp 0"); end
    checks++; if (bad_step) begin errors++; $display("FAIL tick_step_without_tick got 1 exp 0"); end
    checks++; if (q7 !== 4'd3) begin errors++; $display("FAIL tick_q_c7 got %0d exp 3", q7); end
    checks++; if (q13 !== 4'd1) begin errors++; $display("FAIL tick_q_c13 got %0d exp 1", q13); end
    checks++; if (done_at != 14) begin errors++; $display("FAIL tick_done_cycle got %0d exp 14", done_at); end
    tick = 1'b1;
  endtask

  task automatic test_boundary();
    int done_at = -1;
    bit ce_seen = 1'b0;
    lo = 4'd7; hi = 4'd7; reps = 4'd1; tick = 1'b1; start = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (done) done_at = c;
      if (cnt_ce) ce_seen = 1'b1;
      checks++; if (busy !== (c <= 4)) begin errors++; $display("FAIL equal_busy_c%0d got %0d exp %0d", c, busy, (c <= 4)); end
    end
    checks++; if (done_at != 4) begin errors++; $display("FAIL equal_done_cycle got %0d exp 4", done_at); end
    checks++; if (ce_seen) begin errors++; $display("FAIL equal_ce_seen got 1 exp 0"); end
    checks++; if (cnt_q !== 4'd7) begin errors++; $display("FAIL equal_q got %0d exp 7", cnt_q); end
  endtask

  task automatic test_error();
    lo = 4'd9; hi = 4'd4; reps = 4'd2; start = 1'b1;
    #1;
    cyc();
    start = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_err_c1 got %0d exp 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL error_busy_c1 got %0d exp 0", busy); end
    cyc();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL error_err_c2 got %0d exp 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL error_busy_c2 got %0d exp 0", busy); end
    checks++; if (rep_done !== 4'd1) begin errors++; $display("FAIL error_rep_done_held got %0d exp 1", rep_done); end
  endtask

  task automatic test_abort();
    bit late_done = 1'b0;
    lo = 4'd2; hi = 4'd5; reps = 4'd1; tick = 1'b1; start = 1'b1;
    #1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
      #1;
    end
    checks++; if (cnt_q !== 4'd4 || cnt_up !== 1'b0) begin errors++; $display("FAIL abort_pre got q=%0d up=%0d exp q=4 up=0", cnt_q, cnt_up); end
    abort = 1'b1;
    #1;
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL abort_cnt_clr got %0d exp 1", cnt_clr); end
    cyc();
    abort = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0d exp 0", busy); end
    checks++; if (cnt_q !== 4'd0) begin errors++; $display("FAIL abort_cnt_q got %0d exp 0", cnt_q); end
    checks++; if (rep_done !== 4'd0) begin errors++; $display("FAIL abort_rep_done got %0d exp 0", rep_done); end
    for (int c = 0; c < 5; c++) begin
      if (done) late_done = 1'b1;
      cyc();
      #1;
    end
    checks++; if (late_done) begin errors++; $display("FAIL abort_done_seen got 1 exp 0"); end
  endtask

  task automatic test_clr_mid();
    lo = 4'd3; hi = 4'd3; reps = 4'd2; tick = 1'b1; start = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      start = 1'b0;
      #1;
    end
    checks++; if (rep_done !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL clrmid_pre got rep_done=%0d busy=%0d exp 1 1", rep_done, busy); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rep_done !== 4'd0) begin
      errors++; $display("FAIL clrmid_status got busy=%0d done=%0d err=%0d rep_done=%0d exp all 0", busy, done, err, rep_done);
    end
  endtask

  task automatic test_back_to_back();
    int done_at = -1;
    bit err_seen = 1'b0;
    logic [M-1:0] q5, q9;
    q5 = '0; q9 = '0;
    lo = 4'd2; hi = 4'd5; reps = 4'd1; tick = 1'b1; start = 1'b1;
    #1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 2) begin lo = 4'd0; hi = 4'd15; end
      start = (c < 10);
      #1;
      if (done) done_at = c;
      if (err) err_seen = 1'b1;
      if (c == 5) q5 = cnt_q;
      if (c == 9) q9 = cnt_q;
    end
    checks++; if (q5 !== 4'd5) begin errors++; $display("FAIL b2b_peak got %0d exp 5", q5); end
    checks++; if (q9 !== 4'd2) begin errors++; $display("FAIL b2b_floor got %0d exp 2", q9); end
    checks++; if (done_at != 10) begin errors++; $display("FAIL b2b_done_cycle got %0d exp 10", done_at); end
    checks++; if (err_seen) begin errors++; $display("FAIL b2b_err got 1 exp 0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0d exp 0", busy); end
  endtask

  task automatic test_abort_priority();
    for (int k = 0; k < 2; k++) begin
      lo = (k == 0) ? 4'd1 : 4'd5;
      hi = (k == 0) ? 4'd2 : 4'd1;
      reps = 4'd1; start = 1'b1; abort = 1'b1;
      #1;
      checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL prio%0d_cnt_clr got %0d exp 1", k, cnt_clr); end
      cyc();
      start = 1'b0; abort = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL prio%0d_status got busy=%0d err=%0d exp 0 0", k, busy, err); end
    end
  endtask

  task automatic test_dwell();
    int done_at = -1;
    int exp_done;
    logic [M-1:0] qa, qb;
`ifdef COUNTER_SEQ_DWELL_EN
    exp_done = 11;
`else
    exp_done = 8;
`endif
    qa = '0; qb = '0;
    lo = 4'd2; hi = 4'd4; reps = 4'd1; tick = 1'b1; start = 1'b1;
    #1;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (done) done_at = c;
      if (c == exp_done - 2) qa = cnt_q;
      if (c == exp_done - 1) qb = cnt_q;
    end
    checks++; if (done_at != exp_done) begin errors++; $display("FAIL dwell_done_cycle got %0d exp %0d", done_at, exp_done); end
    checks++; if (qa !== 4'd3) begin errors++; $display("FAIL dwell_q_pre2 got %0d exp 3", qa); end
    checks++; if (qb !== 4'd2) begin errors++; $display("FAIL dwell_q_pre1 got %0d exp 2", qb); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reps();
    test_reps_zero();
    test_tick_gating();
    test_boundary();
    test_error();
    test_abort();
    test_clr_mid();
    test_back_to_back();
    test_abort_priority();
    test_dwell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
